// File: rtl/dma_fifo_pkg.sv
// Shared DMA constants: default word width, default FIFO depth and the pointer-width helper.
package dma_pkg;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dma_op_e;

    function automatic int unsigned dma_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned DMA_DATA_W = 16;
    localparam int unsigned DMA_DEPTH  = 8;
    localparam int unsigned DMA_PTR_W  = dma_ptr_w(DMA_DEPTH);

endpackage

// File: rtl/dma_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module dma_fifo_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dma_fifo.sv
// DEPTH-entry word FIFO between the DMA transfer engine and the openMSP430 DMA interface.
// Define DMA_FIFO_FWFT_EN for first-word fall-through; otherwise data_out is registered on pop.
module dma_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W    = DMA_DATA_W,
    parameter int unsigned DEPTH     = DMA_DEPTH,
    parameter int unsigned AFULL_LVL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     last_wr,
    output logic                     ovf,
    output logic                     udf
);

    localparam int unsigned     PTR_W   = dma_ptr_w(DEPTH);
    localparam logic [PTR_W:0]  AFULL_C = (PTR_W + 1)'(AFULL_LVL);

    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic [DATA_W-1:0] r_dout;
    logic              r_ovf;
    logic              r_udf;
    dma_op_e           r_last_op;

    logic [PTR_W:0]    w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_count = r_wptr - r_rptr;

    assign w_push = rst && !flush && wr_en && !w_full;
    assign w_pop  = rst && !flush && rd_en && !w_empty;

    dma_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr[PTR_W-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rptr[PTR_W-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_dout    <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_last_op <= OP_RD;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_udf <= 1'b1;
            end
            if (w_push) begin
                r_last_op <= OP_WR;
            end else if (w_pop) begin
                r_last_op <= OP_RD;
            end
`ifdef DMA_FIFO_FWFT_EN
            // Track the head so the last shown word survives the FIFO going empty.
            if (!w_empty) begin
                r_dout <= w_rd_data;
            end
`else
            if (w_pop) begin
                r_dout <= w_rd_data;
            end
`endif
        end
    end

`ifdef DMA_FIFO_FWFT_EN
    assign data_out = w_empty ? r_dout : w_rd_data;
`else
    assign data_out = r_dout;
`endif

    assign full    = w_full;
    assign empty   = w_empty;
    assign afull   = (w_count >= AFULL_C);
    assign count   = w_count;
    assign last_wr = r_last_op;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule

// File: tb/tb_dma_fifo.sv
// Scoreboard bench for dma_fifo: an 8-deep instance for the main sequence and a 4-deep one for wrap-around.
module tb_dma_fifo;
    import dma_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        full, empty, afull, last_wr, ovf, udf;
    logic [DMA_PTR_W:0] count;

    logic        wr4 = 1'b0;
    logic        rd4 = 1'b0;
    logic [15:0] din4 = '0;
    logic [15:0] dout4;
    logic        full4, empty4, afull4, last_wr4, ovf4, udf4;
    logic [2:0]  count4;

    dma_fifo #(.DATA_W(16), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .full(full), .empty(empty),
        .afull(afull), .count(count), .last_wr(last_wr), .ovf(ovf), .udf(udf)
    );

    dma_fifo #(.DATA_W(16), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr4), .data_in(din4),
        .rd_en(rd4), .data_out(dout4), .full(full4), .empty(empty4),
        .afull(afull4), .count(count4), .last_wr(last_wr4), .ovf(ovf4), .udf(udf4)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] q[$];
    logic [15:0] q4[$];
    int m_cnt = 0;
    int m4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nodata(input string name);
        total++;
        bad++;
        $display("FAIL %s: pop observed but no word expected", name);
    endtask

    // Scoreboard monitors: compare a word whenever the DUT hands one over.
    logic mon_go, mon_go4;
`ifdef DMA_FIFO_FWFT_EN
    assign mon_go  = rst && !flush && rd_en && !empty;
    assign mon_go4 = rst && !flush && rd4 && !empty4;
`else
    logic pend = 1'b0;
    logic pend4 = 1'b0;
    always @(posedge clk) begin
        pend  <= rst && !flush && rd_en && !empty;
        pend4 <= rst && !flush && rd4 && !empty4;
    end
    assign mon_go  = pend;
    assign mon_go4 = pend4;
`endif

    always @(negedge clk) begin
        if (mon_go) begin
            if (q.size() == 0) nodata("dout");
            else chk("dout", 32'(data_out), 32'(q.pop_front()));
        end
        if (mon_go4) begin
            if (q4.size() == 0) nodata("dout4");
            else chk("dout4", 32'(dout4), 32'(q4.pop_front()));
        end
    end

    task automatic cyc(input logic w, input logic [15:0] d, input logic r);
        logic push_ok, pop_ok;
        wr_en = w; data_in = d; rd_en = r;
        if (rst && !flush) begin
            push_ok = w && (m_cnt < 8);
            pop_ok  = r && (m_cnt > 0);
            if (push_ok) q.push_back(d);
            m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic cyc4(input logic w, input logic [15:0] d, input logic r);
        logic push_ok, pop_ok;
        wr4 = w; din4 = d; rd4 = r;
        if (rst && !flush) begin
            push_ok = w && (m4 < 4);
            pop_ok  = r && (m4 > 0);
            if (push_ok) q4.push_back(d);
            m4 = m4 + int'(push_ok) - int'(pop_ok);
        end
        @(posedge clk); #1;
        wr4 = 1'b0; rd4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_last_wr", 32'(last_wr), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_udf", 32'(udf), 0);
        rst = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            cyc(1, 16'(i), 0);
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_afull", 32'(afull), 32'(i >= 6));
            chk("fill_full", 32'(full), 32'(i == 8));
`ifdef DMA_FIFO_FWFT_EN
            chk("fwft_head", 32'(data_out), 32'h1);
`endif
        end
        chk("fill_ovf", 32'(ovf), 0);
        chk("fill_last_wr", 32'(last_wr), 1);

        cyc(1, 16'hDEAD, 0);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 8);

        for (int i = 0; i < 8; i++) cyc(0, '0, 1);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_last_wr", 32'(last_wr), 0);
        chk("drain_dout", 32'(data_out), 32'h8);

        cyc(0, '0, 1);
        chk("udf_set", 32'(udf), 1);
        chk("udf_count", 32'(count), 0);
        chk("udf_dout_hold", 32'(data_out), 32'h8);

        flush = 1'b1;
        cyc(1, 16'h5555, 0);
        flush = 1'b0;
        chk("flush_udf", 32'(udf), 0);
        chk("flush_ovf", 32'(ovf), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_last_wr", 32'(last_wr), 0);
        chk("flush_dout", 32'(data_out), 32'h8);

        cyc(1, 16'h0010, 0);
        cyc(1, 16'h0011, 0);
        cyc(1, 16'h0012, 0);
        cyc(1, 16'h0013, 1);
        chk("simul_count", 32'(count), 3);
        chk("simul_last_wr", 32'(last_wr), 1);

        // 4-deep instance: prime, 20 push+pop cycles around the ring, then fill and drain.
        cyc4(1, 16'h0100, 0);
        cyc4(1, 16'h0101, 0);
        for (int i = 0; i < 20; i++) cyc4(1, 16'(16'h0102 + i), 1);
        chk("wrap_count", 32'(count4), 2);
        cyc4(1, 16'h0200, 0);
        cyc4(1, 16'h0201, 0);
        chk("wrap_full", 32'(full4), 1);
        chk("wrap_afull", 32'(afull4), 1);
        for (int i = 0; i < 4; i++) cyc4(0, '0, 1);
        chk("wrap_empty", 32'(empty4), 1);

        cyc(1, 16'h0014, 0);
        cyc(1, 16'h0015, 0);
        chk("pre_rst_count", 32'(count), 5);
        rst = 1'b0;
        flush = 1'b1;
        cyc(1, 16'h7777, 1);
        q.delete();
        m_cnt = 0;
        q4.delete();
        m4 = 0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_dout", 32'(data_out), 0);
        chk("midrst_last_wr", 32'(last_wr), 0);
        rst = 1'b1;
        flush = 1'b0;

        cyc(1, 16'hA5A5, 0);
`ifdef DMA_FIFO_FWFT_EN
        chk("fwft_fall", 32'(data_out), 32'hA5A5);
`else
        chk("reg_no_fall", 32'(data_out), 0);
`endif
        chk("a5_empty", 32'(empty), 0);
        cyc(0, '0, 1);
        chk("a5_pop_empty", 32'(empty), 1);
        chk("a5_pop_dout", 32'(data_out), 32'hA5A5);
        cyc(0, '0, 0);
        chk("a5_dout_hold", 32'(data_out), 32'hA5A5);

        chk("q_drained", 32'(q.size()), 0);
        chk("q4_drained", 32'(q4.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_fifo.md
# dma_fifo

Parametrised synchronous FIFO between the DMA controller's transfer engine and the openMSP430 DMA interface. It replaces the single-word register buffer with a DEPTH-entry word queue. It adds full/empty/level status, almost-full back-pressure, sticky overflow/underflow error bits and a flush. The last-operation-was-write flag is retained for protocol compatibility.

## Interface
- DATA_W, 16: word width in bits.
- DEPTH, 8: number of entries; power of two, 2..256.
- AFULL_LVL, DEPTH-2: `afull` asserts when `count` >= AFULL_LVL; valid range 1..DEPTH.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset; one clock, synchronous and active-low (0 = reset).
- flush  in  1  synchronous clear of contents and error bits; ignored while rst=0.
- wr_en  in  1  push request.
- data_in  in  DATA_W  push data.
- rd_en  in  1  pop request.
- data_out  out  DATA_W  read data.
- full  out  1  DEPTH entries stored.
- empty  out  1  zero entries stored.
- afull  out  1  count >= AFULL_LVL.
- count  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH.
- last_wr  out  1  1 = most recent accepted operation was a write.
- ovf  out  1  sticky: a push was attempted while full.
- udf  out  1  sticky: a pop was attempted while empty.

## Operation
- Reset values: count=0, empty=1, full=0, afull=0 (or 1 if AFULL_LVL=0 is ever allowed; it is not), data_out=0, last_wr=0, ovf=0, udf=0. Pointers=0.
- A push is accepted iff wr_en=1 and full=0. The entry is written at wptr, and wptr increments modulo DEPTH.
- A pop is accepted iff rd_en=1 and empty=0. rptr increments modulo DEPTH.
- Simultaneous accepted push and pop leave count unchanged. When full, a push is rejected even if a pop occurs in the same cycle. When empty, a pop is rejected even if a push occurs in the same cycle.
- Rejected push sets ovf; rejected pop sets udf. Stored data and pointers are unaffected.
- last_wr updates only on accepted operations: push → 1, pop → 0, both → 1.
- Pointers carry one extra wrap bit. full = (ptr MSBs differ and lower bits equal); empty = (pointers equal). count = wptr − rptr, computed in $clog2(DEPTH)+1 bits.
- flush=1 sets both pointers to 0 and clears ovf and udf. Push and pop are ignored in that cycle. last_wr and data_out hold their values.
- rst=0 takes priority over flush and over all operations. A reset mid-burst discards contents.

## Timing
- All status outputs are registered or derived from registered pointers; no combinational path from wr_en/rd_en to any output.
- A push in cycle N is visible in count/empty/full from cycle N+1.
- Registered read mode (default): data_out loads mem[rptr] on the edge that accepts the pop, so the value is valid in cycle N+1. data_out holds between pops.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- DMA_FIFO_FWFT_EN defined: first-word fall-through.
  - data_out = mem[rptr] whenever empty=0, updating the cycle after the first push into an empty FIFO.
  - rd_en acknowledges and removes the head word.
  - When empty, data_out holds its last value.
- DMA_FIFO_FWFT_EN undefined: registered read mode as described in Timing.

## Structure
- Package dma_pkg holds shared DMA constants: default DATA_W (16), default DEPTH (8), and the pointer-width helper localparam.
- One sub-module, dma_fifo_mem: DEPTH×DATA_W storage with one synchronous write port and an asynchronous read port. The memory has no reset; its contents are undefined after reset.
- Pointer, count, flag and error logic lives in dma_fifo.

## Test plan
- Reset and fill: rst=0 for 2 cycles → all outputs at reset values. Push 0x0001..0x0008 on consecutive cycles → count 8, full=1, afull=1 from count=6, ovf=0.
- Overflow and drain: with the FIFO full, push 0xDEAD → ovf=1, count stays 8. Pop 8 words → data_out sequence 0x0001..0x0008 (one cycle latency), then empty=1 and last_wr=0.
- Underflow and flush: pop while empty → udf=1, count stays 0. Pulse flush → udf=0, ovf=0, empty=1.
- Simultaneous operation: push and pop in the same cycle at count=3 → count stays 3 and last_wr=1. Run 20 wrap-around cycles with DEPTH=4 → FIFO order preserved.
- Reset mid-operation: rst=0 at count=5 → next cycle count=0, empty=1, data_out=0. flush asserted together with rst=0 has no additional effect.
- FWFT build: with DMA_FIFO_FWFT_EN defined, push 0xA5A5 into an empty FIFO → data_out=0xA5A5 the next cycle without rd_en. rd_en → empty=1 and data_out holds 0xA5A5.
